// File: rtl/inst_buffer_pkg.sv
// Shared constants for the instruction buffer: packet layout, depth, fetch width.
package inst_buffer_pkg;

  localparam int SIZE_INSTRUCTION = 64;
  localparam int SIZE_PC          = 32;
  localparam int SIZE_CTI_LOG     = 2;

  // Packet = instruction + two PCs + CTI log + one flag bit.
  localparam int INST_PKT_W = SIZE_INSTRUCTION + 2 * SIZE_PC + SIZE_CTI_LOG + 1;

  localparam int INST_BUF_DEPTH = 32;
  localparam int FETCH_WIDTH    = 4;

  // Number of set bits in a 4-lane valid vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/inst_buffer_compact.sv
// Lane compaction for the instruction buffer: counts the valid lanes and
// gives each lane its write offset from the tail pointer.
module inst_buffer_compact
  import inst_buffer_pkg::*;
(
  input  logic [3:0] valid_i,
  output logic [2:0] n_in_o,
  output logic [1:0] off0_o,
  output logic [1:0] off1_o,
  output logic [1:0] off2_o,
  output logic [1:0] off3_o
);

  // Each lane's offset is the number of valid lanes below it, so holes collapse.
  always_comb begin
    n_in_o = popcount4(valid_i);
    off0_o = 2'd0;
    off1_o = 2'(valid_i[0]);
    off2_o = 2'(valid_i[0]) + 2'(valid_i[1]);
    off3_o = 2'(valid_i[0]) + 2'(valid_i[1]) + 2'(valid_i[2]);
  end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO between Fetch2->Decode and Decode.
// Accepts whole bundles of up to four packets and hands up to four
// oldest packets per cycle to Decode.
//
// Handshake: an input bundle transfers on a cycle where at least one lane
// valid is high, stall_o is low and flush_i is low (the whole bundle or
// nothing). Output lane K transfers on a cycle where instructionKValid_o is
// high and backEndStall_i is low; all presented lanes leave together.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int PKT_W = INST_PKT_W,
  parameter int DEPTH = INST_BUF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             instruction0Valid_i,
  input  logic             instruction1Valid_i,
  input  logic             instruction2Valid_i,
  input  logic             instruction3Valid_i,
  input  logic [PKT_W-1:0] inst0Packet_i,
  input  logic [PKT_W-1:0] inst1Packet_i,
  input  logic [PKT_W-1:0] inst2Packet_i,
  input  logic [PKT_W-1:0] inst3Packet_i,
  input  logic             backEndStall_i,
  output logic             stall_o,
  output logic             instBufferEmpty_o,
  output logic             instruction0Valid_o,
  output logic             instruction1Valid_o,
  output logic             instruction2Valid_o,
  output logic             instruction3Valid_o,
  output logic [PKT_W-1:0] inst0Packet_o,
  output logic [PKT_W-1:0] inst1Packet_o,
  output logic [PKT_W-1:0] inst2Packet_o,
  output logic [PKT_W-1:0] inst3Packet_o,
  output logic [IDX_W:0]   count_o
);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W:0]   free_slots;

  logic [3:0]       vld_in;
  logic [PKT_W-1:0] pkt_in [4];
  logic [2:0]       n_in;
  logic [1:0]       lane_off [4];
  logic             enq, deq;
  logic [2:0]       n_avail, n_enq, n_deq;
  logic [3:0]       vld_out;
  logic [PKT_W-1:0] pkt_out [4];

  assign vld_in    = {instruction3Valid_i, instruction2Valid_i,
                      instruction1Valid_i, instruction0Valid_i};
  assign pkt_in[0] = inst0Packet_i;
  assign pkt_in[1] = inst1Packet_i;
  assign pkt_in[2] = inst2Packet_i;
  assign pkt_in[3] = inst3Packet_i;

  inst_buffer_compact u_compact (
    .valid_i (vld_in),
    .n_in_o  (n_in),
    .off0_o  (lane_off[0]),
    .off1_o  (lane_off[1]),
    .off2_o  (lane_off[2]),
    .off3_o  (lane_off[3])
  );

  // Stall, group sizes and next-state pointers. Stall depends on the
  // registered count only, so backEndStall_i never reaches stall_o.
  always_comb begin
    free_slots = (IDX_W+1)'(DEPTH) - count_q;
    stall_o    = free_slots < (IDX_W+1)'(FETCH_WIDTH);
    n_avail    = (count_q >= (IDX_W+1)'(FETCH_WIDTH)) ? 3'd4 : count_q[2:0];
    enq        = ~stall_o & ~flush_i & ~reset & (|vld_in);
    deq        = ~backEndStall_i & ~flush_i;
    n_enq      = enq ? n_in : 3'd0;
    n_deq      = deq ? n_avail : 3'd0;
    tail_d     = tail_q + IDX_W'(n_enq);
    head_d     = head_q + IDX_W'(n_deq);
    count_d    = count_q + (IDX_W+1)'(n_enq) - (IDX_W+1)'(n_deq);
  end

  // Pointer and occupancy registers; reset wins over flush, both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage writes: each valid lane lands at tail plus its compacted offset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (enq && vld_in[k]) begin
        mem_q[tail_q + IDX_W'(lane_off[k])] <= pkt_in[k];
      end
    end
  end

  // Head read: lane K shows entry head+K, valid while K is within occupancy.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      pkt_out[k] = mem_q[head_q + IDX_W'(k)];
      vld_out[k] = 3'(k) < n_avail;
    end
  end

  assign instruction0Valid_o = vld_out[0];
  assign instruction1Valid_o = vld_out[1];
  assign instruction2Valid_o = vld_out[2];
  assign instruction3Valid_o = vld_out[3];
  assign inst0Packet_o       = pkt_out[0];
  assign inst1Packet_o       = pkt_out[1];
  assign inst2Packet_o       = pkt_out[2];
  assign inst3Packet_o       = pkt_out[3];
  assign instBufferEmpty_o   = (count_q == '0);
  assign count_o             = count_q;

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    count_q <= (IDX_W+1)'(DEPTH));
  a_ptr_count : assert property (@(posedge clk) disable iff (reset)
    (IDX_W'(tail_q - head_q)) == count_q[IDX_W-1:0]);

endmodule

// File: tb/tb_inst_buffer.sv
// Directed plus random stimulus for inst_buffer, checked against a queue
// holding the packets Decode should see, in order.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int PKT_W = INST_PKT_W;
  localparam int DEPTH = INST_BUF_DEPTH;
  localparam int IDX_W = $clog2(DEPTH);

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             flush_i = 1'b0;
  logic [3:0]       vin = 4'b0;
  logic [PKT_W-1:0] pkt_i [4];
  logic             bes = 1'b0;
  logic             stall_o, empty_o;
  logic [3:0]       vout;
  logic [PKT_W-1:0] pout [4];
  logic [IDX_W:0]   count_o;

  inst_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush_i),
    .instruction0Valid_i (vin[0]),
    .instruction1Valid_i (vin[1]),
    .instruction2Valid_i (vin[2]),
    .instruction3Valid_i (vin[3]),
    .inst0Packet_i       (pkt_i[0]),
    .inst1Packet_i       (pkt_i[1]),
    .inst2Packet_i       (pkt_i[2]),
    .inst3Packet_i       (pkt_i[3]),
    .backEndStall_i      (bes),
    .stall_o             (stall_o),
    .instBufferEmpty_o   (empty_o),
    .instruction0Valid_o (vout[0]),
    .instruction1Valid_o (vout[1]),
    .instruction2Valid_o (vout[2]),
    .instruction3Valid_o (vout[3]),
    .inst0Packet_o       (pout[0]),
    .inst1Packet_o       (pout[1]),
    .inst2Packet_o       (pout[2]),
    .inst3Packet_o       (pout[3]),
    .count_o             (count_o)
  );

  // Scoreboard: packets accepted but not yet consumed, oldest first
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] bund [4];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs,
                     input logic [PKT_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic new_bundle();
    for (int k = 0; k < 4; k++)
      bund[k] = PKT_W'({$urandom(), $urandom(), $urandom(), $urandom(), 3'(k)});
  endtask

  // Driver: one clock of stimulus; checks the head against the scoreboard,
  // then advances the scoreboard by what the cycle should consume/accept.
  task automatic cycle(input logic [3:0] v, input logic stall_in, input logic fl);
    int size_pre, navail;
    logic exp_stall;
    @(negedge clk);
    vin = v;
    for (int k = 0; k < 4; k++) pkt_i[k] = bund[k];
    bes = stall_in;
    flush_i = fl;
    #1;
    size_pre  = exp_q.size();
    navail    = (size_pre > 4) ? 4 : size_pre;
    exp_stall = (DEPTH - size_pre) < 4;
    chk("count", PKT_W'(count_o), PKT_W'(size_pre));
    chk("stall", PKT_W'(stall_o), PKT_W'(exp_stall));
    chk("empty", PKT_W'(empty_o), PKT_W'(size_pre == 0));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), PKT_W'(vout[k]), PKT_W'(k < navail));
      if (k < navail) chk($sformatf("pkt%0d", k), pout[k], exp_q[k]);
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      if (!stall_in) repeat (navail) void'(exp_q.pop_front());
      if (!exp_stall)
        for (int k = 0; k < 4; k++) if (v[k]) exp_q.push_back(bund[k]);
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input logic [3:0] v);
    @(negedge clk);
    reset = 1'b1;
    vin = v;
    for (int k = 0; k < 4; k++) pkt_i[k] = bund[k];
    bes = 1'b0;
    flush_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vin = 4'b0;
    exp_q.delete();
  endtask

  task automatic peek_count(input string tag, input int exp);
    #1;
    chk(tag, PKT_W'(count_o), PKT_W'(exp));
  endtask

  initial begin
    for (int k = 0; k < 4; k++) pkt_i[k] = '0;
    new_bundle();
    do_reset(4'b0000);
    cycle(4'b0000, 1'b0, 1'b0);               // reset state

    // Full bundle: visible next cycle as 1111 in order, then drained
    new_bundle(); cycle(4'b1111, 1'b0, 1'b0);
    new_bundle(); cycle(4'b0000, 1'b0, 1'b0);
    peek_count("after_full_drain", 0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Sparse 1010 while back end stalled, then released
    new_bundle(); cycle(4'b1010, 1'b1, 1'b0);
    peek_count("sparse_count", 2);
    new_bundle(); cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Fill to full with back end stalled; extra bundles ignored
    for (int i = 0; i < 10; i++) begin
      new_bundle(); cycle(4'b1111, 1'b1, 1'b0);
    end
    peek_count("full_count", 32);
    for (int i = 0; i < 9; i++) cycle(4'b0000, 1'b0, 1'b0);

    // Head is now at 6; six streamed bundles bring it to 30, then straddle the wrap
    for (int i = 0; i < 6; i++) begin
      new_bundle(); cycle(4'b1111, 1'b0, 1'b0);
    end
    cycle(4'b0000, 1'b0, 1'b0);
    new_bundle(); cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // count=5 with simultaneous dequeue of 4 and enqueue of 4
    new_bundle(); cycle(4'b1111, 1'b1, 1'b0);
    new_bundle(); cycle(4'b0100, 1'b1, 1'b0);
    new_bundle(); cycle(4'b1111, 1'b0, 1'b0);
    peek_count("simul_count", 5);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Flush at count 17 with a valid bundle present
    for (int i = 0; i < 4; i++) begin
      new_bundle(); cycle(4'b1111, 1'b1, 1'b0);
    end
    new_bundle(); cycle(4'b0001, 1'b1, 1'b0);
    peek_count("pre_flush_count", 17);
    new_bundle(); cycle(4'b1111, 1'b0, 1'b1);
    peek_count("post_flush_count", 0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Reset mid-stream with a valid bundle present
    for (int i = 0; i < 3; i++) begin
      new_bundle(); cycle(4'b1011, 1'b1, 1'b0);
    end
    new_bundle(); do_reset(4'b1111);
    cycle(4'b0000, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      new_bundle();
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
